// File: rtl/rotate_arbiter_if.sv
// Handshake bundle between the two rotate requesters, the shared rotator and
// its downstream consumer. The arbiter uses the slave view; the request
// sources plus the consumer together form the master view.
interface rotate_arbiter_if;
    logic       a_valid;
    logic [7:0] a_data;
    logic [2:0] a_amt;
    logic       a_left;
    logic       a_ready;

    logic       b_valid;
    logic [7:0] b_data;
    logic [2:0] b_amt;
    logic       b_left;
    logic       b_ready;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_id;
    logic       last_gnt;

    modport master (
        output a_valid, a_data, a_amt, a_left,
        input  a_ready,
        output b_valid, b_data, b_amt, b_left,
        input  b_ready,
        input  out_valid, out_data, out_id, last_gnt,
        output out_ready
    );

    modport slave (
        input  a_valid, a_data, a_amt, a_left,
        output a_ready,
        input  b_valid, b_data, b_amt, b_left,
        output b_ready,
        output out_valid, out_data, out_id, last_gnt,
        input  out_ready
    );
endinterface

// File: rtl/rotate_arbiter.sv
// Two-requester round-robin front end for a single 8-bit rotate-right datapath.
// One request is granted per cycle, rotated, and captured with its source ID
// in a registered output stage that has its own valid/ready handshake.

module barrel_shifter (
    input  logic [7:0] data,
    input  logic [2:0] amt,
    output logic [7:0] res
);
    logic [15:0] doubled;

    // Rotate right: shifting two copies of the byte drops wrapped bits into the low half
    always_comb begin
        doubled = {data, data} >> amt;
        res     = doubled[7:0];
    end
endmodule

module rotate_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    rotate_arbiter_if.slave bus
);
    logic       can_accept;
    logic       grant_a;
    logic       grant_b;
    logic       take;
    logic [7:0] sel_data;
    logic [2:0] sel_amt;
    logic       sel_left;
    logic [2:0] eff;
    logic [7:0] rot_res;

    // Grant and mux the winning request; a tie goes to whoever was not served last
    always_comb begin
        can_accept = !bus.out_valid || bus.out_ready;
        grant_a    = bus.a_valid && (!bus.b_valid || bus.last_gnt);
        grant_b    = bus.b_valid && (!bus.a_valid || !bus.last_gnt);
        take       = can_accept && (grant_a || grant_b);
        sel_data   = grant_b ? bus.b_data : bus.a_data;
        sel_amt    = grant_b ? bus.b_amt  : bus.a_amt;
        sel_left   = grant_b ? bus.b_left : bus.a_left;
        // A left rotate by n is a right rotate by the 3-bit negation of n
        eff        = sel_left ? (3'd0 - sel_amt) : sel_amt;
    end

    assign bus.a_ready = can_accept && grant_a;
    assign bus.b_ready = can_accept && grant_b;

    barrel_shifter u_shifter (
        .data (sel_data),
        .amt  (eff),
        .res  (rot_res)
    );

    // Output register: reload on any grant (even while draining), clear when drained idle, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_id    <= 1'b0;
            bus.last_gnt  <= 1'b1;
        end else if (take) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= rot_res;
            bus.out_id    <= grant_b;
            bus.last_gnt  <= grant_b;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
